// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with a zero-latency hit path and a word-burst line refill.
// Optional performance counters (hit_cnt/miss_cnt) are built when ICACHE_PERF_EN is defined.
module icache_fetch #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] pc_in,
    input  logic        inv,
    output logic [31:0] inst_out,
    output logic        istall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    logic [OFF_W-1:0] beat;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             inv_seen;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             hit;
    logic             launch;
    logic             last_beat;
    logic             unused_pc_bits;

    assign pc_off = pc_in[2 +: OFF_W];
    assign pc_idx = pc_in[2 + OFF_W +: IDX_W];
    assign pc_tag = pc_in[31:TAG_LSB];
    assign unused_pc_bits = ^pc_in[1:0];

    assign hit       = req && (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign launch    = req && (state == IDLE) && !hit;
    assign last_beat = (state == REFILL) && mem_ready && (beat == OFF_W'(WORDS - 1));

    always_comb begin
        state_next = state;
        inst_out   = NOP;
        istall     = req && !hit;
        if (hit) begin
            inst_out = data_mem[pc_idx][pc_off];
        end
        case (state)
            IDLE:    if (launch) state_next = REFILL;
            REFILL:  if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A refill that saw an invalidate still completes its handshake but never marks its line valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= '0;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'd0;
            fill_idx <= '0;
            fill_tag <= '0;
            inv_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                fill_idx <= pc_idx;
                fill_tag <= pc_tag;
                beat     <= '0;
                inv_seen <= 1'b0;
                mem_req  <= 1'b1;
                mem_addr <= {pc_in[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
            end else if (state == REFILL) begin
                if (inv) inv_seen <= 1'b1;
                if (mem_ready) begin
                    beat <= beat + OFF_W'(1);
                    if (last_beat) mem_req <= 1'b0;
                    else           mem_addr <= mem_addr + 32'd4;
                end
            end
            if (inv) valid <= '0;
            if (last_beat && !inv && !inv_seen) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; only the valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if ((state == REFILL) && mem_ready) data_mem[fill_idx][beat] <= mem_rdata;
        if (last_beat) tag_mem[fill_idx] <= fill_tag;
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit)    hit_cnt  <= hit_cnt + 32'd1;
            if (launch) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed plus randomized bench for icache_fetch against a line-level behavioural cache model.
// Also checks hit_cnt/miss_cnt when built with ICACHE_PERF_EN.
module tb_icache_fetch;

    localparam int LINES   = 16;
    localparam int WORDS   = 4;
    localparam int LINE_B  = WORDS * 4;
    localparam int TAG_DIV = LINES * LINE_B;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] pc_in;
    logic        inv;
    logic [31:0] inst_out;
    logic        istall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: which lines hold which tag, and the one outstanding line fill
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    bit          m_busy;
    int unsigned m_base;
    int          m_beats;
    bit          m_inv_seen;
    int unsigned m_hits;
    int unsigned m_misses;
    logic        obs_istall;

    icache_fetch #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pc_in     (pc_in),
        .inv       (inv),
        .inst_out  (inst_out),
        .istall    (istall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_busy     = 1'b0;
        m_beats    = 0;
        m_inv_seen = 1'b0;
        m_hits     = 0;
        m_misses   = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model past the edge
    task automatic step(input logic r, input logic [31:0] pc, input logic iv, input logic rdy);
        int unsigned line;
        int unsigned idx;
        bit          exp_hit;
        req       = r;
        pc_in     = pc;
        inv       = iv;
        mem_ready = rdy;
        mem_rdata = mem_addr;
        #3;
        line    = pc / LINE_B;
        idx     = line % LINES;
        exp_hit = rst && r && !m_busy && m_valid[idx] && (m_tag[idx] == pc / TAG_DIV);
        obs_istall = istall;
        check("istall",   {31'd0, istall},  {31'd0, r && !exp_hit});
        check("inst_out", inst_out, exp_hit ? {pc[31:2], 2'b00} : NOP);
        check("mem_req",  {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy || !rst)
            check("mem_addr", mem_addr, m_busy ? m_base + 32'(4 * m_beats) : 32'd0);
`ifdef ICACHE_PERF_EN
        check("hit_cnt",  hit_cnt,  m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`endif
        if (!rst) begin
            model_reset();
        end else begin
            if (exp_hit) m_hits++;
            if (iv) begin
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
                if (m_busy) m_inv_seen = 1'b1;
            end
            if (m_busy) begin
                if (rdy) begin
                    m_beats++;
                    if (m_beats == WORDS) begin
                        m_busy = 1'b0;
                        m_tag[(m_base / LINE_B) % LINES] = m_base / TAG_DIV;
                        if (!m_inv_seen) m_valid[(m_base / LINE_B) % LINES] = 1'b1;
                    end
                end
            end else if (r && !exp_hit) begin
                m_busy     = 1'b1;
                m_base     = line * LINE_B;
                m_beats    = 0;
                m_inv_seen = 1'b0;
                m_misses++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Fetch one PC until it is serviced; ready_pat bit n drives mem_ready in cycle n
    task automatic fetch(input logic [31:0] pc, input logic [31:0] ready_pat, input int exp_stalls, input string tag);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(1'b1, pc, 1'b0, ready_pat[n]);
            if (!obs_istall) done = 1'b1;
            else             stalls++;
        end
        check({tag, "_serviced"}, {31'd0, done}, 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        rst       = 1'b0;
        req       = 1'b1;
        pc_in     = 32'h100;
        inv       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'd0;
        model_reset();
        #1;

        // Reset state, with req high
        step(1'b1, 32'h100, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        rst = 1'b1;

        // Cold miss, then same-line hits
        fetch(32'h100, 32'hFFFF_FFFF, 5, "cold_miss");
        fetch(32'h104, 32'hFFFF_FFFF, 0, "hit_104");
        fetch(32'h108, 32'hFFFF_FFFF, 0, "hit_108");
        fetch(32'h10C, 32'hFFFF_FFFF, 0, "hit_10c");

        // Conflict eviction on index 0
        fetch(32'h200, 32'hFFFF_FFFF, 5, "evict_200");
        fetch(32'h100, 32'hFFFF_FFFF, 5, "refetch_100");

        // Wait states: ready 1,0,0,1,1,0,1 after the miss cycle
        fetch(32'h300, 32'hFFFF_FFB3, 8, "wait_states");

        // Invalidate pulse during the second refill beat
        step(1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b1, 32'h400, 1'b1, 1'b1);
        step(1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b1, 32'h400, 1'b0, 1'b1);
        fetch(32'h400, 32'hFFFF_FFFF, 5, "after_inv");

        // Reset in the middle of a refill
        step(1'b1, 32'h500, 1'b0, 1'b1);
        step(1'b1, 32'h500, 1'b0, 1'b1);
        step(1'b1, 32'h500, 1'b0, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        step(1'b1, 32'h500, 1'b0, 1'b1);
        rst = 1'b1;
        fetch(32'h500, 32'hFFFF_FFFF, 5, "after_reset");

        // Randomized traffic over a small address set so hits, conflicts and redirects all occur
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            step($urandom_range(0, 9) != 0, pc, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache between the IF stage and external instruction memory. It looks up the fetch PC combinationally and returns the instruction with zero latency on a hit. On a miss it raises `istall` and refills one line from memory with a valid/ready word-burst. The `istall` output drives the PC/IF stall path (`ICacheStall`), and `inst_out` replaces the constant external-instruction tie-off.

## Interface
- `LINES`, 16, number of cache lines (power of 2, ≥2)
- `WORDS`, 4, 32-bit words per line (power of 2, ≥2)
- `clk` input 1, sole clock; all state updates on rising edge
- `rst` input 1, reset, asynchronous, active-low
- `req` input 1, fetch request valid
- `pc_in` input 32, fetch byte address; bits [1:0] ignored
- `inv` input 1, invalidate-all pulse
- `inst_out` output 32, fetched instruction
- `istall` output 1, fetch not serviced this cycle
- `mem_req` output 1, memory beat request (registered)
- `mem_addr` output 32, word-aligned beat address (registered)
- `mem_ready` input 1, memory accepts beat and presents `mem_rdata` this cycle
- `mem_rdata` input 32, returned word

## Operation
- Address split: offset = log2(WORDS) bits above [1:0]; index = next log2(LINES) bits; tag = the remaining upper bits.
- Storage per line: valid bit, tag, and WORDS data words. Data and tag arrays are not reset; only the valid bits are cleared.
- Hit (combinational): `req` & state IDLE & valid[index] & tag match.
  - `inst_out` = data[index][offset].
  - `istall` = 0.
- Miss, idle, or refill:
  - `inst_out` = 32'h00000013 (NOP).
  - `istall` = `req` & !hit.
- FSM states: IDLE, REFILL.
- IDLE → REFILL when `req` & !hit.
  - Latch line base = {pc tag, index, zero offset}.
  - Set beat counter = 0.
  - Set `mem_req` = 1 and `mem_addr` = line base.
- In REFILL, on each cycle with `mem_ready` = 1:
  - Write `mem_rdata` to data[latched index][beat].
  - Increment beat and advance `mem_addr` by 4.
  - `mem_req` and `mem_addr` hold stable while `mem_ready` = 0.
- Last beat (beat = WORDS-1 with `mem_ready`):
  - Write the tag.
  - Set the valid bit, unless `inv` was seen during the refill.
  - Drop `mem_req` and return to IDLE.
- `pc_in` changes during REFILL (e.g. branch redirect) do not affect the refill. The latched line completes, then the new PC is looked up in IDLE.
- `req` dropping during REFILL does not abort the refill.
- `inv` (any state):
  - Clears all valid bits at the next edge.
  - If asserted during REFILL, the refill finishes its handshake but the line is left invalid.
  - If `inv` and a miss occur in the same IDLE cycle, the refill is still launched and its line is marked valid.
- Reset (mid-refill included):
  - State IDLE, all valid = 0, beat = 0.
  - `mem_req` = 0, `mem_addr` = 0.
  - Any in-flight refill is abandoned; the memory side must tolerate `mem_req` dropping.

## Timing
- Hit latency: 0 cycles, combinational from `pc_in`/`req`.
- Miss penalty with `mem_ready` tied high:
  - Miss detected in cycle 0.
  - `mem_req` is high in cycles 1..WORDS.
  - The line becomes valid at the end of cycle WORDS.
  - Hit in cycle WORDS+1, i.e. 5 stall cycles for WORDS=4.
- Each wait cycle (`mem_ready` = 0) adds exactly one cycle.
- Output values during reset: `inst_out` NOP, `istall` equals `req`, `mem_req` 0, `mem_addr` 0.
- `istall` asserts in the miss cycle itself and deasserts in the first hit cycle.

## Configuration
- `ICACHE_PERF_EN` defined: adds two ports.
  - `hit_cnt` output 32: increments each cycle a hit is serviced.
  - `miss_cnt` output 32: increments once per IDLE→REFILL transition.
  - Both reset to 0 and wrap 32'hFFFFFFFF → 0.
- `ICACHE_PERF_EN` undefined: the ports and counters are absent; function is otherwise identical.

## Test plan
- Cold miss: release reset, `req`=1, `pc_in`=0x100, `mem_ready`=1, memory returns addr-as-data.
  - `mem_addr` = 0x100, 0x104, 0x108, 0x10C in cycles 1–4.
  - `istall`=1 for 5 cycles, then `inst_out`=0x100.
- Same-line hits: after the fill, `pc_in`=0x104/0x108/0x10C.
  - `istall`=0 and `inst_out`=0x104/0x108/0x10C in consecutive cycles.
- Conflict eviction: fill 0x100, then fetch 0x200 (same index, LINES=16).
  - Miss and refill from 0x200; refetching 0x100 misses again.
- Wait states: `mem_ready` toggles 1,0,0,1,1,0,1 during a refill.
  - `mem_addr` is held on every 0 cycle.
  - Exactly 4 writes; stall lasts 1+7 cycles.
- Invalidate during refill: `inv` pulse in the second refill beat.
  - The refill completes its 4 beats, the next fetch of the same PC misses, and with `ICACHE_PERF_EN` `miss_cnt`=2.
- Reset mid-refill: drop `rst` after beat 1.
  - `mem_req`=0 immediately.
  - After release, the same PC misses and refills from the line base.
